spi_xip_ctrl: RTL and testbench

- XIP read sequencer that owns the Wishbone slave port of the SPI master core (spi_top) and turns one flash word-read request into the full register sequence: divider, control, TX, slave select, GO, busy poll, RX read, deselect.
- Sits between the APB flash-window decode and spi_top; the external APB/Wishbone mux selects this block while its busy output is high.
- Returns one byte-swapped 32-bit word per request over a valid/ready response channel, with a poll timeout and bus-error reporting.

---
 rtl/spi_xip_pkg.sv | 38 +++
 rtl/spi_wb_xfer.sv | 67 ++++++
 rtl/spi_xip_ctrl.sv | 179 +++++++++++++++++
 tb/tb_spi_xip_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_xip_pkg.sv
// Shared state type and spi_top register map for the XIP read sequencer.
package spi_xip_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WR_DIV,
    WR_CTRL,
    WR_TX0,
    WR_TX1,
    WR_SS,
    WR_GO,
    POLL,
    RD_RX,
    WR_SS_CLR,
    RESP
  } xip_state_e;

  localparam logic [4:0] ADR_TX0  = 5'h00;
  localparam logic [4:0] ADR_RX0  = 5'h00;
  localparam logic [4:0] ADR_TX1  = 5'h04;
  localparam logic [4:0] ADR_CTRL = 5'h10;
  localparam logic [4:0] ADR_DIV  = 5'h14;
  localparam logic [4:0] ADR_SS   = 5'h18;

  localparam int GO_BSY_BIT = 8;
  localparam int ASS_BIT    = 13;
  localparam logic [6:0] CHAR_LEN_64 = 7'h40;

  function automatic logic [31:0] ctrl_word(input logic go);
    logic [31:0] w;
    w = '0;
    w[6:0] = CHAR_LEN_64;
    w[ASS_BIT] = 1'b1;
    w[GO_BSY_BIT] = go;
    return w;
  endfunction

endpackage

// File: rtl/spi_wb_xfer.sv
// Single-transfer classic Wishbone master; strobe is held until ack or err.
module spi_wb_xfer
  import spi_xip_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        we_i,
  input  logic [4:0]  adr_i,
  input  logic [31:0] dat_i,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic [4:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  logic        stb_q;
  logic        we_q;
  logic [4:0]  adr_q;
  logic [31:0] dat_q;
  logic [3:0]  sel_q;

  // start is ignored while a transfer is open, forcing an idle cycle between.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stb_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
    end else if (stb_q) begin
      if (wb_ack_i || wb_err_i) begin
        stb_q <= 1'b0;
        we_q  <= 1'b0;
        adr_q <= '0;
        dat_q <= '0;
        sel_q <= '0;
      end
    end else if (start_i) begin
      stb_q <= 1'b1;
      we_q  <= we_i;
      adr_q <= adr_i;
      dat_q <= dat_i;
      sel_q <= 4'hf;
    end
  end

  assign wb_stb_o = stb_q;
  assign wb_cyc_o = stb_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;

  assign err_o   = stb_q & wb_err_i;
  assign done_o  = stb_q & wb_ack_i & ~wb_err_i;
  assign rdata_o = wb_dat_i;

endmodule

// File: rtl/spi_xip_ctrl.sv
// XIP read sequencer: drives spi_top registers to fetch one flash word per request.
module spi_xip_ctrl
  import spi_xip_pkg::*;
#(
  parameter logic [31:0] DIVIDER    = 32'd0,
  parameter logic [7:0]  SS_MASK    = 8'h01,
  parameter logic [7:0]  CMD_READ   = 8'h03,
  parameter logic [15:0] POLL_LIMIT = 16'd1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic [4:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  xip_state_e  state_q;
  logic [23:0] addr_q;
  logic        cfg_done_q;
  logic [15:0] cnt_q;
  logic        err_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_data_q;

  logic        x_start;
  logic        x_we;
  logic [4:0]  x_adr;
  logic [31:0] x_dat;
  logic        x_done;
  logic        x_err;
  logic [31:0] x_rdata;

  always_comb begin
    x_start = 1'b1;
    x_we    = 1'b1;
    x_adr   = ADR_CTRL;
    x_dat   = '0;
    unique case (state_q)
      WR_DIV: begin
        x_adr = ADR_DIV;
        x_dat = DIVIDER;
      end
      WR_CTRL: x_dat = ctrl_word(1'b0);
      WR_TX0:  x_adr = ADR_TX0;
      WR_TX1: begin
        x_adr = ADR_TX1;
        x_dat = {CMD_READ, addr_q};
      end
      WR_SS: begin
        x_adr = ADR_SS;
        x_dat = {24'h0, SS_MASK};
      end
      WR_GO:  x_dat = ctrl_word(1'b1);
      POLL:   x_we = 1'b0;
      RD_RX: begin
        x_adr = ADR_RX0;
        x_we  = 1'b0;
      end
      WR_SS_CLR: x_adr = ADR_SS;
      default: x_start = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cfg_done_q  <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            state_q <= cfg_done_q ? WR_TX0 : WR_DIV;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            state_q     <= IDLE;
          end
        end
        default: begin
          // Any bus error still routes through the deselect write.
          if (x_err) begin
            err_q <= 1'b1;
            if (state_q == WR_SS_CLR) begin
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              state_q <= WR_SS_CLR;
            end
          end else if (x_done) begin
            case (state_q)
              WR_DIV: state_q <= WR_CTRL;
              WR_CTRL: begin
                cfg_done_q <= 1'b1;
                state_q    <= WR_TX0;
              end
              WR_TX0: state_q <= WR_TX1;
              WR_TX1: state_q <= WR_SS;
              WR_SS:  state_q <= WR_GO;
              WR_GO:  state_q <= POLL;
              POLL: begin
                if (!x_rdata[GO_BSY_BIT]) begin
                  state_q <= RD_RX;
                end else begin
                  cnt_q <= cnt_q + 16'd1;
                  if (cnt_q + 16'd1 == POLL_LIMIT) begin
                    err_q   <= 1'b1;
                    state_q <= WR_SS_CLR;
                  end
                end
              end
              RD_RX: begin
                rsp_data_q <= {x_rdata[7:0], x_rdata[15:8],
                               x_rdata[23:16], x_rdata[31:24]};
                state_q    <= WR_SS_CLR;
              end
              WR_SS_CLR: begin
                rsp_valid_q <= 1'b1;
                state_q     <= RESP;
              end
              default: state_q <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = err_q;

  spi_wb_xfer u_xfer (
    .clk_i    (clock),
    .rst_i    (reset),
    .start_i  (x_start),
    .we_i     (x_we),
    .adr_i    (x_adr),
    .dat_i    (x_dat),
    .done_o   (x_done),
    .err_o    (x_err),
    .rdata_o  (x_rdata),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel_o),
    .wb_we_o  (wb_we_o),
    .wb_stb_o (wb_stb_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i)
  );

endmodule

// File: tb/tb_spi_xip_ctrl.sv
// Directed bench for spi_xip_ctrl with a stand-in spi_top slave and a transfer-list model.
module tb_spi_xip_ctrl;

  localparam int LIMIT = 1024;

  typedef struct packed {
    logic [4:0]  adr;
    logic        we;
    logic [31:0] dat;
    logic        err;
  } xfer_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic [4:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  always #5 clock = ~clock;

  spi_xip_ctrl dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  // spi_top stand-in: always acks, injects armed errors, reports busy for N polls
  logic [31:0] rx_word = '0;
  int          busy_polls = 0;
  int          poll_base = 0;
  int          polls_seen = 0;
  int          err_req = 0;
  int          err_served = 0;
  logic [4:0]  err_adr [0:7];
  logic        ctrl_busy;

  assign ctrl_busy = (polls_seen - poll_base) < busy_polls;
  assign wb_ack_i  = wb_stb_o;
  assign wb_err_i  = wb_stb_o && (err_served < err_req)
                     && (wb_adr_o == err_adr[err_served[2:0]]);
  assign wb_dat_i  = (wb_adr_o == 5'h10) ? (ctrl_busy ? 32'h0000_2140 : 32'h0000_2040)
                   : (wb_adr_o == 5'h00) ? rx_word : 32'h0;

  logic [4:0]  lg_adr [0:8191];
  logic        lg_we  [0:8191];
  logic [31:0] lg_dat [0:8191];
  logic        lg_err [0:8191];
  int          lg_n = 0;

  int tests = 0;
  int fails = 0;
  bit pend_v = 0;
  bit pend_err = 0;
  bit pend_poll = 0;

  bit          cfg_ok = 0;
  logic [31:0] exp_data = '0;
  logic        exp_err = 1'b0;
  logic [31:0] cap_data = '0;
  logic        cap_err = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One cycle: settle slave bookkeeping after the edge, then compare and log mid-cycle.
  task automatic tick();
    @(posedge clock);
    #1;
    if (pend_v) begin
      if (pend_err) err_served++;
      else if (pend_poll) polls_seen++;
      pend_v = 0;
    end
    @(negedge clock);
    check("cyc_eq_stb", {31'b0, wb_cyc_o}, {31'b0, wb_stb_o});
    check("busy_vs_ready", {31'b0, busy}, {31'b0, !req_ready});
    if (wb_stb_o) check("sel", {28'b0, wb_sel_o}, 32'hf);
    if (rsp_valid) begin
      check("rsp_data", rsp_data, exp_data);
      check("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
    end
    if (wb_stb_o && !reset) begin
      lg_adr[lg_n] = wb_adr_o;
      lg_we[lg_n]  = wb_we_o;
      lg_dat[lg_n] = wb_dat_o;
      lg_err[lg_n] = wb_err_i;
      lg_n++;
      pend_v    = 1;
      pend_err  = wb_err_i;
      pend_poll = (wb_adr_o == 5'h10) && !wb_we_o;
    end
  endtask

  function automatic xfer_t mk(input logic [4:0] a, input logic w, input logic [31:0] d);
    return '{adr: a, we: w, dat: d, err: 1'b0};
  endfunction

  function automatic int count_polls(input int from);
    int c = 0;
    for (int i = from; i < lg_n; i++)
      if (lg_adr[i] == 5'h10 && !lg_we[i]) c++;
    return c;
  endfunction

  task automatic run_req(input logic [23:0] a, input logic [31:0] rx, input int nbusy,
                         input int nerr, input logic [4:0] e0, input logic [4:0] e1,
                         input int stall, input bit chain, input logic [23:0] nxt,
                         output int base);
    xfer_t q[$];
    bit    tmo;
    int    n;
    int    k;
    rx_word    = rx;
    busy_polls = nbusy;
    poll_base  = polls_seen;
    if (nerr > 0) begin err_adr[err_req[2:0]] = e0; err_req++; end
    if (nerr > 1) begin err_adr[err_req[2:0]] = e1; err_req++; end

    // Expected bus traffic from the sequence rules
    if (!cfg_ok) begin
      q.push_back(mk(5'h14, 1, 32'h0));
      q.push_back(mk(5'h10, 1, 32'h0000_2040));
    end
    q.push_back(mk(5'h00, 1, 32'h0));
    q.push_back(mk(5'h04, 1, {8'h03, a}));
    q.push_back(mk(5'h18, 1, 32'h1));
    q.push_back(mk(5'h10, 1, 32'h0000_2140));
    tmo = nbusy >= LIMIT;
    n = tmo ? LIMIT : nbusy + 1;
    repeat (n) q.push_back(mk(5'h10, 0, 32'h0));
    if (!tmo) q.push_back(mk(5'h00, 0, 32'h0));
    q.push_back(mk(5'h18, 1, 32'h0));
    if (nerr > 0) begin
      k = 0;
      while (q[k].adr != e0) k++;
      q[k].err = 1'b1;
      while (q.size() > k + 1) void'(q.pop_back());
      q.push_back(mk(5'h18, 1, 32'h0));
      if (nerr > 1) q[q.size()-1].err = 1'b1;
    end
    exp_err = tmo || (nerr > 0);
    foreach (q[i]) begin
      if (q[i].adr == 5'h10 && q[i].we && q[i].dat == 32'h2040 && !q[i].err) cfg_ok = 1;
      if (q[i].adr == 5'h00 && !q[i].we && !q[i].err) exp_data = {<<8{rx}};
    end

    base = lg_n;
    req_addr  = a;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("accepted", {31'b0, busy}, 32'h1);
    for (int w = 0; w < 6000 && !rsp_valid; w++) tick();
    check("rsp_arrived", {31'b0, rsp_valid}, 32'h1);
    cap_data = rsp_data;
    cap_err  = rsp_err;
    for (int i = 0; i < stall; i++) begin
      if (chain) begin
        req_valid = 1'b1;
        req_addr  = nxt;
      end
      tick();
      check("rsp_held", {31'b0, rsp_valid}, 32'h1);
      check("no_accept", {31'b0, req_ready}, 32'h0);
      check("bus_quiet", {31'b0, wb_stb_o}, 32'h0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_dropped", {31'b0, rsp_valid}, 32'h0);
    check("back_idle", {31'b0, req_ready}, 32'h1);

    check("n_xfers", lg_n - base, q.size());
    for (int i = 0; i < q.size() && base + i < lg_n; i++) begin
      check($sformatf("x%0d_adr", i), {27'b0, lg_adr[base+i]}, {27'b0, q[i].adr});
      check($sformatf("x%0d_we", i), {31'b0, lg_we[base+i]}, {31'b0, q[i].we});
      check($sformatf("x%0d_err", i), {31'b0, lg_err[base+i]}, {31'b0, q[i].err});
      if (q[i].we) check($sformatf("x%0d_dat", i), lg_dat[base+i], q[i].dat);
    end
  endtask

  initial begin
    int b;
    for (int i = 0; i < 8; i++) err_adr[i] = '0;
    repeat (3) tick();
    check("rst_req_ready", {31'b0, req_ready}, 32'h1);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_wb", {wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o} == '0 ? 32'h0 : 32'h1, 32'h0);
    reset = 1'b0;
    tick();

    run_req(24'h00_1234, 32'hAABB_CCDD, 1, 0, 5'h0, 5'h0, 0, 0, 24'h0, b);
    check("pin_data1", cap_data, 32'hDDCC_BBAA);
    check("pin_err1", {31'b0, cap_err}, 32'h0);
    check("pin_first_div", {27'b0, lg_adr[b]}, 32'h14);
    check("pin_tx1", lg_dat[b+3], 32'h0300_1234);

    run_req(24'hFF_FFFC, 32'h0102_0304, 0, 0, 5'h0, 5'h0, 0, 0, 24'h0, b);
    check("pin_first_tx0", {27'b0, lg_adr[b]}, 32'h00);
    check("pin_tx1_2", lg_dat[b+1], 32'h03FF_FFFC);
    check("pin_data2", cap_data, 32'h0403_0201);

    run_req(24'h00_0040, 32'h1122_3344, 5, 0, 5'h0, 5'h0, 0, 0, 24'h0, b);
    check("pin_6_polls", count_polls(b), 32'd6);

    run_req(24'h00_0080, 32'h5566_7788, 0, 1, 5'h04, 5'h0, 0, 0, 24'h0, b);
    check("pin_err_tx1", {31'b0, cap_err}, 32'h1);
    check("pin_clr_after_err", {27'b0, lg_adr[b+2]}, 32'h18);

    run_req(24'h00_00C0, 32'h99AA_BBCC, 0, 0, 5'h0, 5'h0, 0, 0, 24'h0, b);
    check("pin_restart_tx0", {27'b0, lg_adr[b]}, 32'h00);

    run_req(24'h00_0100, 32'h0BAD_F00D, 0, 2, 5'h04, 5'h18, 0, 0, 24'h0, b);
    check("pin_double_err", {31'b0, cap_err}, 32'h1);

    run_req(24'h00_0200, 32'hCAFE_BABE, 0, 0, 5'h0, 5'h0, 10, 1, 24'h00_ABCD, b);
    check("pin_stall_data", cap_data, 32'hBEBA_FECA);
    run_req(24'h00_ABCD, 32'h1357_9BDF, 2, 0, 5'h0, 5'h0, 0, 0, 24'h0, b);

    run_req(24'h00_0300, 32'h2468_ACE0, LIMIT - 1, 0, 5'h0, 5'h0, 0, 0, 24'h0, b);
    check("pin_limit_ok", {31'b0, cap_err}, 32'h0);
    check("pin_limit_polls", count_polls(b), 32'd1024);

    run_req(24'h00_0400, 32'h0, 5000, 0, 5'h0, 5'h0, 0, 0, 24'h0, b);
    check("pin_timeout_err", {31'b0, cap_err}, 32'h1);
    check("pin_timeout_polls", count_polls(b), 32'd1024);

    // reset while polling
    rx_word    = 32'h7777_7777;
    busy_polls = 100;
    poll_base  = polls_seen;
    req_addr   = 24'h00_0500;
    req_valid  = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int w = 0; w < 500 && (polls_seen - poll_base) < 3; w++) tick();
    check("reached_poll", polls_seen - poll_base, 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_stb", {31'b0, wb_stb_o}, 32'h0);
    check("rst_mid_busy", {31'b0, busy}, 32'h0);
    check("rst_mid_ready", {31'b0, req_ready}, 32'h1);
    cfg_ok   = 0;
    exp_data = '0;
    b = lg_n;
    repeat (5) tick();
    check("no_deselect", lg_n - b, 32'd0);

    run_req(24'h12_3456, 32'hDEAD_BEEF, 0, 0, 5'h0, 5'h0, 0, 0, 24'h0, b);
    check("pin_div_again", {27'b0, lg_adr[b]}, 32'h14);
    check("pin_data_last", cap_data, 32'hEFBE_ADDE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
